// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register-bank write sink: drain FSM states,
// register file geometry and address decode helpers.
package reg_bank_pkg;

    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } drain_state_t;

    // Bits [31:28] and [1:0] are don't-care; anything set in [27:6] is outside the bank.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr[27:6] == 22'd0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[5:2];
    endfunction

endpackage

// File: rtl/reg_bank_sink_wr_buf.sv
// Circular write buffer (module wr_buf): wrap-around pointers plus an occupancy
// count one bit wider than the pointers so full and empty are distinguishable.
module wr_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/reg_bank_sink.sv
// Buffered register-bank write sink: requests queue in wr_buf and a drain FSM
// retires one per WRITE cycle. Optional dropped-write counter: REG_BANK_SINK_ERR_CNT_EN.
module reg_bank_sink
    import reg_bank_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 S_valid,
    input  logic [31:0]          S_addr,
    input  logic [31:0]          S_data,
    output logic                 S_ready,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [31:0]          rd_data,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          err_cnt,
    output drain_state_t         state_dbg
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    drain_state_t     state, state_next;
    logic [3:0]       wait_cnt;
    logic [31:0]      regs [NUM_REGS];
    logic             push, pop, full, empty;
    logic [63:0]      head;
    logic [CNT_W-1:0] count;
    logic [31:0]      head_addr, head_data;
    logic             head_in_range;

    // Handshake: a request transfers on a rising edge where S_valid && S_ready;
    // S_ready is !full from registered occupancy, so a same-cycle pop never frees a slot early.
    assign S_ready = !full;
    assign push    = S_valid && !full;
    assign pop     = (state == WRITE);

    wr_buf #(.DEPTH(DEPTH), .W(64)) u_wr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({S_addr, S_data}),
        .pop       (pop),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head_addr     = head[63:32];
    assign head_data     = head[31:0];
    assign head_in_range = addr_in_range(head_addr);
    assign err           = pop && !head_in_range;
    assign busy          = (count != '0) || (state != IDLE);
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!empty) state_next = WRITE;
            WRITE: begin
                // A simultaneous push keeps back-to-back draining going when there is no gap.
                if (WAIT_CYCLES > 0)                   state_next = WAIT;
                else if ((count > CNT_W'(1)) || push)  state_next = WRITE;
                else                                   state_next = IDLE;
            end
            WAIT:  if (wait_cnt <= 4'd1) state_next = empty ? IDLE : WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (state == WRITE) wait_cnt <= 4'(WAIT_CYCLES);
        else if (state == WAIT)  wait_cnt <= wait_cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (pop && head_in_range) begin
            regs[addr_index(head_addr)] <= head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= regs[rd_addr];
    end

`ifdef REG_BANK_SINK_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt_q <= '0;
        else if (err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'd0;
`endif

endmodule
